// File: rtl/fe_uop_arb.sv
// fe_uop_arb: shares the uop-cache input port between the decoder (DEC) and the
// microcode sequencer (MC). Multi-beat groups are atomic, and the two sources never
// interleave inside a group. A small registered FIFO isolates the consumer's
// out_ready from the source-facing ready signals.

package ez90_pkg;

  // One micro-op as carried from the front end into the uop cache.
  typedef struct packed {
    logic [7:0] opcode;
    logic [4:0] dst;
    logic [4:0] src_a;
    logic [4:0] src_b;
    logic [8:0] imm;
  } ez90_uop_t;

endpackage

module fe_uop_arb
  import ez90_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,  // power of 2, >= 2
  parameter int MC_PRIO    = 0   // 0: round-robin at group boundaries, 1: MC strict priority
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,

  input  logic      dec_valid,
  input  ez90_uop_t dec_uop,
  input  logic      dec_last,
  output logic      dec_ready,

  input  logic      mc_valid,
  input  ez90_uop_t mc_uop,
  input  logic      mc_last,
  output logic      mc_ready,

  output logic      out_valid,
  output ez90_uop_t out_uop,
  input  logic      out_ready,

  output logic      grant_mc,
  output logic      busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOCK_DEC = 2'd1,
    ST_LOCK_MC  = 2'd2
  } state_e;

  // Arbitration state
  state_e           state_q,      state_d;
  logic             rr_last_mc_q, rr_last_mc_d;  // owner of the last completed group (1 = MC)
  logic             grant_mc_q,   grant_mc_d;

  // FIFO state
  logic [CNT_W-1:0] count_q,  count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  ez90_uop_t        mem_q [FIFO_DEPTH];

  // Datapath between arbiter and FIFO
  logic             sel_mc;
  logic             space_avail;
  logic             accept_en;
  logic             push;
  logic             pop;
  ez90_uop_t        push_uop;
  logic             push_last;

  // Pick the source that owns the port this cycle.
  // NOTE: every signal written in an always_comb gets a default on entry, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_mc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mc_valid && dec_valid) begin
          // Tie: MC_PRIO picks MC outright; otherwise alternate against the last owner.
          sel_mc = (MC_PRIO != 0) ? 1'b1 : ~rr_last_mc_q;
        end else begin
          sel_mc = mc_valid;
        end
      end
      ST_LOCK_DEC: sel_mc = 1'b0;
      ST_LOCK_MC:  sel_mc = 1'b1;
      default:     sel_mc = 1'b0;
    endcase
  end

  // Ready and push depend on registered FIFO occupancy only. A pop in the same cycle
  // earns no credit, so out_ready never reaches dec_ready or mc_ready.
  always_comb begin
    space_avail = (count_q < CNT_W'(FIFO_DEPTH));
    accept_en   = space_avail & ~flush & ~rst;
    dec_ready   = accept_en & ~sel_mc;
    mc_ready    = accept_en &  sel_mc;
    push        = sel_mc ? (mc_valid & mc_ready) : (dec_valid & dec_ready);
    push_uop    = sel_mc ? mc_uop  : dec_uop;
    push_last   = sel_mc ? mc_last : dec_last;
    out_valid   = (count_q != '0);
    pop         = out_valid & out_ready;
  end

  // Group tracking: open a lock on a non-final beat, release it on the final beat.
  always_comb begin
    state_d      = state_q;
    rr_last_mc_d = rr_last_mc_q;
    grant_mc_d   = grant_mc_q;
    if (push) begin
      // The first beat of a group, accepted from IDLE, names the new owner.
      if (state_q == ST_IDLE) begin
        grant_mc_d = sel_mc;
      end
      if (push_last) begin
        state_d      = ST_IDLE;
        rr_last_mc_d = sel_mc;
      end else begin
        state_d = sel_mc ? ST_LOCK_MC : ST_LOCK_DEC;
      end
    end
    // A flush drops any partial group. The round-robin history is left untouched.
    if (flush) begin
      state_d = ST_IDLE;
    end
  end

  // FIFO pointer and occupancy update. A flush empties the FIFO and discards
  // any pop offered in the same cycle.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State register for control and FIFO bookkeeping.
  // NOTE: sequential state uses non-blocking assignments, so every flop samples the
  // values from before the edge regardless of the order in which statements run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_last_mc_q <= 1'b0;
      grant_mc_q   <= 1'b0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      rr_last_mc_q <= rr_last_mc_d;
      grant_mc_q   <= grant_mc_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // FIFO payload storage. A write happens only on an accepted beat.
  // NOTE: the storage array has no reset. An entry is read only after a write that
  // count_q tracks, and the head is forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_uop;
    end
  end

  // Drive the outputs. The head is masked to zero while the FIFO is empty, so the
  // idle output is clean after reset or flush.
  always_comb begin
    out_uop  = out_valid ? mem_q[rd_ptr_q] : '0;
    grant_mc = grant_mc_q;
    busy     = out_valid | (state_q != ST_IDLE);
  end

endmodule
